// File: rtl/akuma_death_sequencer.sv
// Akuma KO/death animation sequencer: HIT -> FALL (knockback) -> LIE -> DONE.
// Optional corpse blink at the end of LIE is enabled with AKUMA_DEATH_BLINK_EN.
module akuma_death_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 6,
  parameter int LIE_TICKS   = 90,
  parameter int KNOCK_DX    = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 404,
  parameter int BLINK_TICKS = 8
) (
  input  logic                          vga_clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          ko,
  input  logic                          clear,
  input  logic [9:0]                    start_x,
  input  logic [9:0]                    start_y,
  input  logic                          knock_right,
  output logic [9:0]                    sprite_x,
  output logic [9:0]                    sprite_y,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          death_active,
  output logic                          sprite_visible,
  output logic                          done
);
  localparam int FW   = $clog2(NUM_FRAMES);
  localparam int MAXA = (FRAME_TICKS > LIE_TICKS) ? FRAME_TICKS : LIE_TICKS;
  localparam int MAXT = (MAXA > BLINK_TICKS) ? MAXA : BLINK_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic signed [10:0] DX_S   = 11'(KNOCK_DX);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
`ifdef AKUMA_DEATH_BLINK_EN
  localparam int BLINK_START = LIE_TICKS - LIE_TICKS / 2;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_HIT, ST_FALL, ST_LIE, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [9:0]      x_reg, x_next, y_reg, y_next;
  logic [FW-1:0]   frame_reg, frame_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic            dir_reg, dir_next;
  logic            active_reg, active_next;
  logic            vis_reg, vis_next;
  logic            done_reg, done_next;
`ifdef AKUMA_DEATH_BLINK_EN
  logic [CW-1:0]   blink_reg, blink_next;
`endif
  logic signed [10:0] x_ext, x_moved, start_ext;

  // Saturate a signed 11-bit position into the on-screen range, never wrapping.
  function automatic logic [9:0] sat_x(input logic signed [10:0] v);
    if (v < XMIN_S)      return 10'(X_MIN);
    else if (v > XMAX_S) return 10'(X_MAX);
    else                 return v[9:0];
  endfunction

  assign x_ext     = $signed({1'b0, x_reg});
  assign start_ext = $signed({1'b0, start_x});
  assign x_moved   = dir_reg ? (x_ext + DX_S) : (x_ext - DX_S);
  assign cnt_inc   = cnt_reg + CW'(1);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      frame_reg  <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      active_reg <= 1'b0;
      vis_reg    <= 1'b0;
      done_reg   <= 1'b0;
`ifdef AKUMA_DEATH_BLINK_EN
      blink_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      frame_reg  <= frame_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      active_reg <= active_next;
      vis_reg    <= vis_next;
      done_reg   <= done_next;
`ifdef AKUMA_DEATH_BLINK_EN
      blink_reg  <= blink_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    frame_next  = frame_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    active_next = active_reg;
    vis_next    = vis_reg;
    done_next   = done_reg;
`ifdef AKUMA_DEATH_BLINK_EN
    blink_next  = blink_reg;
`endif
    // clear takes priority over ko and frame_tick; in IDLE it also blocks a KO.
    if (clear) begin
      state_next  = ST_IDLE;
      x_next      = '0;
      y_next      = '0;
      frame_next  = '0;
      cnt_next    = '0;
      dir_next    = 1'b0;
      active_next = 1'b0;
      vis_next    = 1'b0;
      done_next   = 1'b0;
`ifdef AKUMA_DEATH_BLINK_EN
      blink_next  = '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: if (ko) begin
          state_next  = ST_HIT;
          x_next      = sat_x(start_ext);
          y_next      = start_y;
          dir_next    = knock_right;
          frame_next  = '0;
          cnt_next    = '0;
          active_next = 1'b1;
          vis_next    = 1'b1;
        end
        ST_HIT: if (frame_tick) begin
          if (cnt_reg == CW'(FRAME_TICKS - 1)) begin
            state_next = ST_FALL;
            cnt_next   = '0;
            frame_next = FW'(1);
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_FALL: if (frame_tick) begin
          x_next = sat_x(x_moved);
          if (cnt_reg == CW'(FRAME_TICKS - 1)) begin
            cnt_next = '0;
            if (frame_reg == FW'(NUM_FRAMES - 1)) state_next = ST_LIE;
            else                                  frame_next = frame_reg + FW'(1);
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_LIE: if (frame_tick) begin
          if (cnt_reg == CW'(LIE_TICKS - 1)) begin
            state_next  = ST_DONE;
            cnt_next    = '0;
            active_next = 1'b0;
            done_next   = 1'b1;
`ifdef AKUMA_DEATH_BLINK_EN
            vis_next    = 1'b0;
`endif
          end else begin
            cnt_next = cnt_inc;
`ifdef AKUMA_DEATH_BLINK_EN
            // Blink phase starts hidden once half the lying time remains.
            if (cnt_inc == CW'(BLINK_START)) begin
              vis_next   = 1'b0;
              blink_next = '0;
            end else if (cnt_inc > CW'(BLINK_START)) begin
              if (blink_reg == CW'(BLINK_TICKS - 1)) begin
                vis_next   = ~vis_reg;
                blink_next = '0;
              end else begin
                blink_next = blink_reg + CW'(1);
              end
            end
`endif
          end
        end
        ST_DONE: ;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign sprite_x       = x_reg;
  assign sprite_y       = y_reg;
  assign frame_idx      = frame_reg;
  assign death_active   = active_reg;
  assign sprite_visible = vis_reg;
  assign done           = done_reg;
endmodule

// File: tb/tb_akuma_death_sequencer.sv
// Self-checking bench for akuma_death_sequencer: directed and randomized KO sequences
// compared against a tick-count-based reference model.
module tb_akuma_death_sequencer;
  localparam int NF = 3, FT = 2, LT = 4, DX = 2, XMN = 0, XMX = 404, BT = 1;
  localparam int TOTAL = NF * FT + LT;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1, frame_tick = 1'b0, ko = 1'b0, clear = 1'b0;
  logic [9:0] start_x = '0, start_y = '0;
  logic       knock_right = 1'b0;
  logic [9:0] sprite_x, sprite_y;
  logic [1:0] frame_idx;
  logic       death_active, sprite_visible, done;

  int checks = 0;
  int errors = 0;
  int last_x;

  akuma_death_sequencer #(
    .NUM_FRAMES(NF), .FRAME_TICKS(FT), .LIE_TICKS(LT), .KNOCK_DX(DX),
    .X_MIN(XMN), .X_MAX(XMX), .BLINK_TICKS(BT)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .ko(ko), .clear(clear),
    .start_x(start_x), .start_y(start_y), .knock_right(knock_right),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_idx(frame_idx),
    .death_active(death_active), .sprite_visible(sprite_visible), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampx(input int v);
    return (v < XMN) ? XMN : (v > XMX) ? XMX : v;
  endfunction

  // Position after n qualifying ticks: only ticks spent in FALL move the sprite.
  function automatic int model_x(input int sx, input bit kr, input int n);
    int m = n - FT;
    if (m < 0) m = 0;
    if (m > (NF - 1) * FT) m = (NF - 1) * FT;
    return clampx(kr ? clampx(sx) + DX * m : clampx(sx) - DX * m);
  endfunction

  function automatic int model_vis(input int n);
    int e;
    int e0;
`ifdef AKUMA_DEATH_BLINK_EN
    if (n >= TOTAL) return 0;
    if (n < NF * FT) return 1;
    e  = n - NF * FT;
    e0 = LT - LT / 2;
    if (e < e0) return 1;
    return ((e - e0) / BT) % 2;
`else
    e  = n;
    e0 = 0;
    return (e >= e0) ? 1 : 0;
`endif
  endfunction

  task automatic check_seq(input string tag, input int n, input int sx, input int sy, input bit kr);
    int fr = n / FT;
    if (fr > NF - 1) fr = NF - 1;
    check({tag, "_x"}, sprite_x, model_x(sx, kr, n));
    check({tag, "_y"}, sprite_y, sy);
    check({tag, "_frame"}, frame_idx, fr);
    check({tag, "_active"}, death_active, (n < TOTAL) ? 1 : 0);
    check({tag, "_done"}, done, (n >= TOTAL) ? 1 : 0);
    check({tag, "_vis"}, sprite_visible, model_vis(n));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"}, sprite_x, 0);
    check({tag, "_y"}, sprite_y, 0);
    check({tag, "_frame"}, frame_idx, 0);
    check({tag, "_active"}, death_active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_vis"}, sprite_visible, 0);
  endtask

  task automatic step(input bit t, input bit k, input bit c);
    frame_tick = t; ko = k; clear = c;
    @(posedge vga_clk);
    @(negedge vga_clk);
    frame_tick = 1'b0; ko = 1'b0; clear = 1'b0;
  endtask

  // Full KO sequence with random gaps and ignored ko pulses; abort_at>0 clears on that tick.
  task automatic run_seq(input int sx, input int sy, input bit kr, input int abort_at,
                         input bit tick_with_ko, output int x_at_done);
    x_at_done = -1;
    start_x = 10'(sx); start_y = 10'(sy); knock_right = kr;
    step(tick_with_ko, 1'b1, 1'b0);
    start_x = 10'($urandom_range(0, 1023));
    start_y = 10'($urandom_range(0, 1023));
    knock_right = 1'($urandom_range(0, 1));
    check_seq("hit0", 0, sx, sy, kr);
    for (int t = 1; t <= TOTAL; t++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, ($urandom_range(0, 3) == 0), 1'b0);
        check_seq("gap", t - 1, sx, sy, kr);
      end
      if (t == abort_at) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        check_idle("abort");
        return;
      end
      step(1'b1, ($urandom_range(0, 3) == 0), 1'b0);
      check_seq("tick", t, sx, sy, kr);
    end
    step(1'b1, 1'b1, 1'b0);
    check_seq("done_hold", TOTAL, sx, sy, kr);
    x_at_done = sprite_x;
    step(1'b0, 1'b1, 1'b1);
    check_idle("done_clear");
  endtask

  initial begin
    Reset = 1'b1;
    @(negedge vga_clk);
    step(1'b1, 1'b1, 1'b0);
    check_idle("reset");
    Reset = 1'b0;

    step(1'b1, 1'b1, 1'b1);
    check_idle("idle_ko_clear");

    run_seq(100, 355, 1'b1, 0, 1'b1, last_x);
    check("nominal_final_x", last_x, 108);
    run_seq(400, 20, 1'b1, 0, 1'b0, last_x);
    check("right_clamp_x", last_x, 404);
    run_seq(3, 40, 1'b0, 0, 1'b0, last_x);
    check("left_clamp_x", last_x, 0);
    run_seq(900, 7, 1'b0, 0, 1'b1, last_x);
    check("latch_clamp_x", last_x, 396);
    run_seq(100, 355, 1'b1, 4, 1'b0, last_x);

    // ko held through a clear restarts one cycle after IDLE is entered.
    start_x = 10'd200; start_y = 10'd50; knock_right = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 1'b0);
    check_seq("pre_clear", 3, 200, 50, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_idle("held_ko_clear");
    step(1'b0, 1'b1, 1'b0);
    check_seq("held_ko_restart", 0, 200, 50, 1'b0);

    // Reset mid-sequence beats clear, ko and frame_tick.
    step(1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check_idle("mid_reset");
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check_idle("post_reset");

    for (int i = 0; i < 24; i++) begin
      int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TOTAL) : 0;
      run_seq($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
              ab, 1'($urandom_range(0, 1)), last_x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
